// File: rtl/alu_pkg.sv
// alu_pkg: opcode encodings and opcode width shared by the ALU pipeline
package alu_pkg;
  localparam int OP_W = 3;
  typedef enum logic [OP_W-1:0] {
    OP_ADD   = 3'b000,
    OP_SUB   = 3'b001,
    OP_AND   = 3'b010,
    OP_OR    = 3'b011,
    OP_XOR   = 3'b100,
    OP_XNOR  = 3'b101,
    OP_ACC   = 3'b110,
    OP_PASSA = 3'b111
  } op_e;
endpackage

// File: rtl/alu_lane.sv
// alu_lane: combinational single-lane ALU producing result and carry/no-borrow/overflow
module alu_lane import alu_pkg::*; #(
  parameter int WIDTH = 8
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [WIDTH-1:0] acc,
  input  op_e              op,
  output logic [WIDTH-1:0] y,
  output logic             c
);
  logic [WIDTH:0] add, sub, sum;
  assign add = {1'b0, a} + {1'b0, b};
  assign sub = {1'b0, a} - {1'b0, b};
  assign sum = {1'b0, acc} + {1'b0, a};
  always_comb begin
    y = a;
    c = 1'b0;
    case (op)
      OP_ADD:  {c, y} = add;
      OP_SUB:  begin y = sub[WIDTH-1:0]; c = ~sub[WIDTH]; end
      OP_AND:  y = a & b;
      OP_OR:   y = a | b;
      OP_XOR:  y = a ^ b;
      OP_XNOR: y = ~(a ^ b);
      OP_ACC:  {c, y} = sum;
      default: y = a;
    endcase
  end
endmodule

// File: rtl/multi_alu_pipe.sv
// multi_alu_pipe: two-stage multi-lane ALU pipeline with per-lane accumulators and valid/ready handshake
module multi_alu_pipe import alu_pkg::*; #(
  parameter int WIDTH    = 8,
  parameter int CHANNELS = 2,
  parameter int ACC_EN   = 1
) (
  input  logic                      wb_clk_i,
  input  logic                      wb_rst_ni,
  input  logic                      active,
  input  logic                      in_valid,
  output logic                      in_ready,
  input  logic [CHANNELS*WIDTH-1:0] a,
  input  logic [CHANNELS*WIDTH-1:0] b,
  input  logic [CHANNELS*OP_W-1:0]  op,
  input  logic                      acc_clr,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic [CHANNELS*WIDTH-1:0] result,
  output logic [CHANNELS-1:0]       carry,
  output logic [CHANNELS-1:0]       zero,
  output logic [CHANNELS-1:0]       parity
);
  logic                      s1_valid, s2_valid, adv1, adv2, move;
  logic [CHANNELS*WIDTH-1:0] s1_a, s1_b, y;
  logic [CHANNELS*OP_W-1:0]  s1_op;
  logic [CHANNELS-1:0]       c, z, p;
  assign adv2      = !s2_valid || out_ready;
  assign adv1      = !s1_valid || adv2;
  assign move      = active && adv2 && s1_valid;
  assign in_ready  = wb_rst_ni && active && adv1;
  assign out_valid = active && s2_valid;
  for (genvar k = 0; k < CHANNELS; k++) begin : g_lane
    op_e              raw, lop;
    logic [WIDTH-1:0] acc, base;
    assign raw  = op_e'(s1_op[k*OP_W +: OP_W]);
    assign lop  = (ACC_EN == 0 && raw == OP_ACC) ? OP_PASSA : raw;
    assign base = acc_clr ? '0 : acc;
    alu_lane #(.WIDTH(WIDTH)) u_lane (
      .a   (s1_a[k*WIDTH +: WIDTH]),
      .b   (s1_b[k*WIDTH +: WIDTH]),
      .acc (base),
      .op  (lop),
      .y   (y[k*WIDTH +: WIDTH]),
      .c   (c[k])
    );
    assign z[k] = ~|y[k*WIDTH +: WIDTH];
    assign p[k] = ^y[k*WIDTH +: WIDTH];
    always_ff @(posedge wb_clk_i)
      if (!wb_rst_ni) acc <= '0;
      else if (move && lop == OP_ACC) acc <= y[k*WIDTH +: WIDTH];
      else if (acc_clr) acc <= '0;
  end
  always_ff @(posedge wb_clk_i)
    if (!wb_rst_ni) begin
      s1_valid <= 1'b0;
      s2_valid <= 1'b0;
      result   <= '0;
      carry    <= '0;
      zero     <= '1;
      parity   <= '0;
    end else if (active) begin
      if (adv2) begin
        s2_valid <= s1_valid;
        if (s1_valid) begin
          result <= y;
          carry  <= c;
          zero   <= z;
          parity <= p;
        end
      end
      if (adv1) s1_valid <= in_valid;
    end
  always_ff @(posedge wb_clk_i)
    if (wb_rst_ni && active && adv1 && in_valid) begin
      s1_a  <= a;
      s1_b  <= b;
      s1_op <= op;
    end
endmodule

// File: tb/tb_multi_alu_pipe.sv
// tb_multi_alu_pipe: randomized and directed scoreboard bench for multi_alu_pipe
module tb_multi_alu_pipe;
  localparam int W = 8, C = 2;
  logic clk = 0, rst_n = 0, active = 0, in_valid = 0, acc_clr = 0, out_ready = 0;
  logic in_ready, out_valid;
  logic [C*W-1:0] a = '0, b = '0, result;
  logic [C*3-1:0] op = '0;
  logic [C-1:0] carry, zero, parity;
  int tests = 0, fails = 0;
  bit rand_ready = 0;
  typedef struct packed {logic [15:0] r; logic [1:0] c; logic [1:0] z; logic [1:0] p;} exp_t;
  exp_t q[$];
  int macc[C];

  always #5 clk = ~clk;

  multi_alu_pipe #(.WIDTH(W), .CHANNELS(C), .ACC_EN(1)) dut (
    .wb_clk_i(clk), .wb_rst_ni(rst_n), .active(active), .in_valid(in_valid), .in_ready(in_ready),
    .a(a), .b(b), .op(op), .acc_clr(acc_clr), .out_valid(out_valid), .out_ready(out_ready),
    .result(result), .carry(carry), .zero(zero), .parity(parity)
  );

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, got, exp);
    end
  endtask

  // Reference: each lane computed from the opcode table with integer arithmetic
  function automatic exp_t model(input logic [15:0] av, input logic [15:0] bv, input logic [5:0] ov);
    exp_t e;
    for (int k = 0; k < C; k++) begin
      int x, y, s;
      logic [7:0] r;
      logic cy;
      x = int'(av[k*8 +: 8]);
      y = int'(bv[k*8 +: 8]);
      cy = 1'b0;
      case (ov[k*3 +: 3])
        3'd0: begin s = x + y; cy = (s > 255); end
        3'd1: begin s = x - y; cy = (x >= y); end
        3'd2: s = x & y;
        3'd3: s = x | y;
        3'd4: s = x ^ y;
        3'd5: s = ~(x ^ y);
        3'd6: begin s = macc[k] + x; cy = (s > 255); macc[k] = s % 256; end
        default: s = x;
      endcase
      r = s[7:0];
      e.r[k*8 +: 8] = r;
      e.c[k] = cy;
      e.z[k] = (r == 8'd0);
      e.p[k] = ^r;
    end
    return e;
  endfunction

  task automatic send(input logic [15:0] av, input logic [15:0] bv, input logic [5:0] ov,
                      input bit clr, output int waits);
    bit ok;
    a = av; b = bv; op = ov; in_valid = 1;
    waits = 0;
    forever begin
      #1 ok = in_ready;
      @(negedge clk);
      if (ok) break;
      waits++;
      if (waits > 100) begin
        tests++; fails++;
        $display("FAIL send_timeout: in_ready stayed 0 for %0d cycles", waits);
        break;
      end
    end
    if (ok) begin
      if (clr) for (int k = 0; k < C; k++) macc[k] = 0;
      q.push_back(model(av, bv, ov));
    end
    in_valid = 0;
    acc_clr = clr;
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
    acc_clr = 0;
  endtask

  task automatic drain();
    int t = 0;
    while (q.size() > 0 && t < 200) begin @(negedge clk); t++; end
    check("drain_empty", q.size(), 0);
  endtask

  always @(negedge clk) if (rand_ready) out_ready = 1'($urandom_range(0, 1));

  always @(negedge clk) begin
    #2;
    if (out_valid) begin
      if (q.size() == 0) begin
        tests++; fails++;
        $display("FAIL unexpected_output: result=%h with no pending bundle", result);
      end else begin
        check("result", result, q[0].r);
        check("carry", carry, q[0].c);
        check("zero", zero, q[0].z);
        check("parity", parity, q[0].p);
        if (out_ready) void'(q.pop_front());
      end
    end
  end

  initial begin
    int w;
    active = 1;
    repeat (2) @(negedge clk);
    #1;
    check("rst_out_valid", out_valid, 0);
    check("rst_in_ready", in_ready, 0);
    check("rst_zero", zero, 2'b11);
    check("rst_result", result, 0);
    check("rst_carry", carry, 0);
    check("rst_parity", parity, 0);
    @(negedge clk);
    rst_n = 1;
    out_ready = 1;
    @(negedge clk);
    send(16'h05F0, 16'h0720, {3'd1, 3'd0}, 0, w);
    @(negedge clk);
    #1;
    check("add_sub_result", result, 16'hFE10);
    check("add_sub_carry", carry, 2'b01);
    check("add_sub_zero", zero, 2'b00);
    drain();
    out_ready = 0;
    for (int i = 0; i < 3; i++) begin
      send(16'h8080, 16'h0000, {3'd6, 3'd6}, 0, w);
      idle(5);
      out_ready = 1;
      @(negedge clk);
      out_ready = 0;
    end
    out_ready = 1;
    drain();
    send(16'hD5D5, 16'h0000, {3'd6, 3'd6}, 0, w);
    drain();
    send(16'h3333, 16'h0000, {3'd6, 3'd6}, 1, w);
    idle(1);
    drain();
    send(16'hAAAA, 16'hFFFF, {3'd4, 3'd4}, 0, w);
    active = 0;
    repeat (4) begin
      #1;
      check("inactive_out_valid", out_valid, 0);
      check("inactive_in_ready", in_ready, 0);
      @(negedge clk);
    end
    active = 1;
    @(negedge clk);
    #1;
    check("resume_result", result, 16'h5555);
    check("resume_parity", parity, 2'b00);
    drain();
    for (int i = 0; i < 16; i++) begin
      send(16'($urandom), 16'($urandom), 6'($urandom), 0, w);
      check("b2b_in_ready", w, 0);
      if (i >= 1) begin #1; check("b2b_out_valid", out_valid, 1); end
    end
    drain();
    rand_ready = 1;
    for (int i = 0; i < 200; i++) begin
      send(16'($urandom), 16'($urandom), 6'($urandom), 0, w);
      idle($urandom_range(0, 2));
    end
    rand_ready = 0;
    @(negedge clk);
    out_ready = 1;
    drain();
    out_ready = 0;
    send(16'h1111, 16'h2222, 6'd0, 0, w);
    send(16'h3333, 16'h4444, 6'd0, 0, w);
    rst_n = 0;
    #1 check("midrst_in_ready", in_ready, 0);
    @(negedge clk);
    q.delete();
    for (int k = 0; k < C; k++) macc[k] = 0;
    @(negedge clk);
    rst_n = 1;
    out_ready = 1;
    repeat (5) begin
      #1 check("postrst_out_valid", out_valid, 0);
      @(negedge clk);
    end
    send(16'h0000, 16'h0000, {3'd6, 3'd6}, 0, w);
    @(negedge clk);
    #1;
    check("postrst_acc_result", result, 16'h0000);
    check("postrst_acc_zero", zero, 2'b11);
    drain();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/multi_alu_pipe.md
MULTI_ALU_PIPE -- requirements
Module: multi_alu_pipe

Interface
REQ-001 Parameter WIDTH, default 8: operand/result width per channel, legal 4..32.
REQ-002 Parameter CHANNELS, default 2: number of independent ALU lanes, legal 1..8.
REQ-003 Parameter ACC_EN, default 1: 1 enables the per-lane accumulator (op ACC); 0 makes ACC behave as PASSA.
REQ-004 wb_clk_i  input  1  sole clock; all state on rising edge.
REQ-005 wb_rst_ni  input  1  reset, synchronous, active-low.
REQ-006 active  input  1  macro enable; 0 freezes the pipeline.
REQ-007 in_valid  input  1  operand bundle valid.
REQ-008 in_ready  output  1  block can accept the bundle this cycle.
REQ-009 a  input  CHANNELS*WIDTH  operand A, lane k at [k*WIDTH +: WIDTH].
REQ-010 b  input  CHANNELS*WIDTH  operand B, same packing.
REQ-011 op  input  CHANNELS*3  per-lane opcode, lane k at [k*3 +: 3].
REQ-012 acc_clr  input  1  synchronous clear of all lane accumulators.
REQ-013 out_valid  output  1  result bundle valid.
REQ-014 out_ready  input  1  consumer accepts the result this cycle.
REQ-015 result  output  CHANNELS*WIDTH  per-lane result.
REQ-016 carry  output  CHANNELS  per-lane carry / no-borrow / accumulator overflow.
REQ-017 zero  output  CHANNELS  per-lane result==0.
REQ-018 parity  output  CHANNELS  per-lane XOR-reduction of result.

Function
REQ-019 Opcodes SHALL be: 000 ADD, 001 SUB (a-b), 010 AND, 011 OR, 100 XOR, 101 XNOR, 110 ACC, 111 PASSA.
REQ-020 ADD carry SHALL be bit WIDTH of a+b; SUB carry SHALL be 1 when a>=b (no borrow); all logic ops and PASSA SHALL give carry 0.
REQ-021 Arithmetic SHALL wrap modulo 2^WIDTH.
REQ-022 ACC SHALL set acc_k <= acc_k + a_k; result = new acc_k; carry = overflow of that add.
REQ-023 Pipeline SHALL be two register stages (S1 operand capture, S2 compute/result); latency from accepted input to out_valid = 2 cycles when unstalled.
REQ-024 Input transfer SHALL occur when in_valid && in_ready; output transfer when out_valid && out_ready.
REQ-025 S2 SHALL advance when S2 empty or out_ready; S1 SHALL advance when S1 empty or S2 advances; in_ready = active && S1 advances condition.
REQ-026 Throughput SHALL be one bundle per cycle with out_ready held 1; no bubble insertion.
REQ-027 result/carry/zero/parity/out_valid SHALL be registered and stable while out_valid && !out_ready.
REQ-028 active=0 SHALL force in_ready=0 and out_valid=0 and hold all pipeline and accumulator state; on return to 1 the held bundle SHALL reappear unchanged.
REQ-029 Accumulator update SHALL occur only when the ACC bundle moves S1->S2, so a stalled ACC bundle is applied exactly once.
REQ-030 acc_clr with an ACC bundle moving S1->S2 in the same cycle SHALL give acc_k = a_k (clear first, then add); acc_clr SHALL work regardless of active.
REQ-031 Lanes SHALL be fully independent except shared handshake.

Reset
REQ-032 wb_rst_ni=0 at a clock edge SHALL clear S1/S2 valid, all accumulators, result, carry, parity to 0, zero to all-ones, in_ready to 0 during reset.
REQ-033 Reset mid-transfer SHALL discard in-flight bundles; no output after reset release until a new accepted input.

Structure
REQ-034 Opcode encodings and op width SHALL live in shared package alu_pkg.
REQ-035 One sub-module alu_lane (combinational op + carry for one lane, parameter WIDTH) SHALL be instantiated CHANNELS times via generate.

Verification (WIDTH=8, CHANNELS=2)
REQ-036 Lane0 ADD a=0xF0 b=0x20, lane1 SUB a=0x05 b=0x07 -> 2 cycles later result0=0x10 carry0=1, result1=0xFE carry1=0, zero=00.
REQ-037 Back-to-back 16 bundles, out_ready=1 -> 16 results in order, in_ready never 0, out_valid continuous.
REQ-038 ACC a=0x80 three times with out_ready=0 for 5 cycles between -> results 0x80, 0x00 (carry=1), 0x80; each applied once.
REQ-039 acc_clr asserted with ACC a=0x33 entering S2, prior acc=0x55 -> result 0x33.
REQ-040 active=0 for 4 cycles with bundle XOR 0xAA^0xFF pending -> out_valid=0; after active=1 result=0x55 parity=0.
REQ-041 wb_rst_ni=0 with two bundles in flight -> out_valid stays 0 after release; accumulators read 0 on next ACC a=0.
